// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (I) and data (D).
// One outstanding access; a watchdog forces an error response on a hung memory.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  output logic            i_err,
  input  logic            d_req,
  input  logic [DW/8-1:0] d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            d_err,
  output logic            m_req,
  output logic [DW/8-1:0] m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic            m_ready,
  input  logic            m_rvalid,
  input  logic [DW-1:0]   m_rdata,
  output logic            busy
);
  localparam int BW = DW / 8;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          first_q, first_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [BW-1:0] we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [CW-1:0] wd_q, wd_d;
  logic          i_rvalid_q, i_rvalid_d;
  logic          d_rvalid_q, d_rvalid_d;
  logic          i_err_q, i_err_d;
  logic          d_err_q, d_err_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  logic          win;
  logic          done;
  logic          err;
  logic          expired;
  logic [DW-1:0] rdata;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    first_d    = 1'b0;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    wd_d       = wd_q;
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    i_err_d    = 1'b0;
    d_err_d    = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    win        = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    rdata      = '0;
    expired    = (TIMEOUT != 0) && (wd_q == WD_LAST);

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          // 1 = D; on a tie the port that did not win last time goes
          win     = (i_req && d_req) ? ~last_q : d_req;
          owner_d = win;
          last_d  = win;
          addr_d  = win ? d_addr : i_addr;
          we_d    = win ? d_we : '0;
          wdata_d = win ? d_wdata : '0;
          wd_d    = '0;
          first_d = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        wd_d = wd_q + 1'b1;
        if (expired) begin
          done = 1'b1;
          err  = 1'b1;
        end else if (m_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        wd_d = wd_q + 1'b1;
        // a response arriving on the expiry cycle still counts
        if (m_rvalid) begin
          done  = 1'b1;
          rdata = (|we_q) ? '0 : m_rdata;
        end else if (expired) begin
          done = 1'b1;
          err  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      state_d = IDLE;
      if (owner_q) begin
        d_rvalid_d = 1'b1;
        d_err_d    = err;
        d_rdata_d  = rdata;
      end else begin
        i_rvalid_d = 1'b1;
        i_err_d    = err;
        i_rdata_d  = rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      first_q    <= 1'b0;
      addr_q     <= '0;
      we_q       <= '0;
      wdata_q    <= '0;
      wd_q       <= '0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_err_q    <= 1'b0;
      d_err_q    <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      first_q    <= first_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      wd_q       <= wd_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      i_err_q    <= i_err_d;
      d_err_q    <= d_err_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign m_req    = (state_q == REQ);
  assign m_addr   = addr_q;
  assign m_we     = we_q;
  assign m_wdata  = wdata_q;
  assign i_gnt    = m_req && first_q && !owner_q;
  assign d_gnt    = m_req && first_q && owner_q;
  assign i_rvalid = i_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign i_err    = i_err_q;
  assign d_err    = d_err_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule
